// File: rtl/simt_pc_stack_if.sv
// Decode/scheduler-side bus of the SIMT program-counter stack.
// The master modport is the core driving decode info; the slave modport is the PC stack.
interface simt_pc_stack_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int STACK_DEPTH           = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                             launch;
  logic [THREADS_PER_BLOCK-1:0]     thread_enable;
  logic [2:0]                       core_state;
  logic                             decoded_pc_mux;
  logic [2:0]                       decoded_nzp;
  logic [DATA_MEM_DATA_BITS-1:0]    decoded_immediate;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_reconv_pc;
  logic [3*THREADS_PER_BLOCK-1:0]   nzp;

  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc;
  logic [THREADS_PER_BLOCK-1:0]     active_mask;
  logic [DW-1:0]                    stack_depth;
  logic                             stack_overflow;

  modport master (
    output launch, thread_enable, core_state, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_reconv_pc, nzp,
    input  current_pc, active_mask, stack_depth, stack_overflow
  );

  modport slave (
    input  launch, thread_enable, core_state, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_reconv_pc, nzp,
    output current_pc, active_mask, stack_depth, stack_overflow
  );
endinterface

// File: rtl/simt_pc_stack.sv
// Shared per-block PC with SIMT branch divergence and a reconvergence stack.
// Divergent paths are serialised; each path pops back when it reaches its reconvergence PC.
module simt_pc_stack #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int STACK_DEPTH           = 4
) (
  input logic             clk,
  input logic             reset,
  simt_pc_stack_if.slave  bus
);
  localparam int T  = THREADS_PER_BLOCK;
  localparam int PW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [2:0] EXECUTE = 3'b101;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [T-1:0]  mask;
    logic [PW-1:0] rpc;
  } entry_t;

  entry_t        active_q;
  entry_t        stack_q [STACK_DEPTH];
  logic [DW-1:0] depth_q;
  logic          overflow_q;

  logic [T-1:0]  taken;
  logic [T-1:0]  not_taken;
  logic [PW-1:0] seq_pc;
  logic [PW-1:0] tgt_pc;
  logic [PW-1:0] recon_pc;
  logic [PW-1:0] cand_pc;
  logic          execute;
  logic          any_taken;
  logic          divergent;
  logic          single_push;
  logic [DW-1:0] pushes_needed;
  logic [DW-1:0] free_slots;
  logic          no_room;
  logic          do_pop;
  logic          push_en;
  entry_t        tos;

  always_comb begin
    taken = '0;
    for (int i = 0; i < T; i++) begin
      taken[i] = active_q.mask[i] & (|(bus.nzp[3*i +: 3] & bus.decoded_nzp));
    end
  end

  assign not_taken = active_q.mask & ~taken;
  assign seq_pc    = active_q.pc + PW'(1);
  assign tgt_pc    = bus.decoded_immediate[PW-1:0];
  assign recon_pc  = bus.decoded_reconv_pc;
  assign execute   = (bus.core_state == EXECUTE) && (active_q.mask != '0);
  assign any_taken = |taken;

  assign divergent = bus.decoded_pc_mux && any_taken && (taken != active_q.mask)
                     && (tgt_pc != seq_pc);
  assign cand_pc   = (bus.decoded_pc_mux && any_taken) ? tgt_pc : seq_pc;

  // A path that falls straight into the reconvergence point needs no stack entry of its own.
  assign single_push   = (seq_pc == recon_pc) || (tgt_pc == recon_pc);
  assign pushes_needed = single_push ? DW'(1) : DW'(2);
  assign free_slots    = DW'(STACK_DEPTH) - depth_q;
  assign no_room       = pushes_needed > free_slots;

  assign do_pop  = !divergent && (depth_q != '0) && (cand_pc == active_q.rpc);
  assign push_en = execute && !bus.launch && divergent && !no_room;

  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == depth_q - DW'(1)) tos = stack_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q   <= '0;
      depth_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.launch) begin
      active_q   <= '{pc: '0, mask: bus.thread_enable, rpc: '0};
      depth_q    <= '0;
      overflow_q <= 1'b0;
    end else if (execute) begin
      if (divergent) begin
        if (no_room) begin
          overflow_q  <= 1'b1;
          active_q.pc <= tgt_pc;
        end else if (seq_pc == recon_pc) begin
          active_q <= '{pc: tgt_pc, mask: taken, rpc: recon_pc};
          depth_q  <= depth_q + DW'(1);
        end else if (tgt_pc == recon_pc) begin
          active_q <= '{pc: seq_pc, mask: not_taken, rpc: recon_pc};
          depth_q  <= depth_q + DW'(1);
        end else begin
          active_q <= '{pc: seq_pc, mask: not_taken, rpc: recon_pc};
          depth_q  <= depth_q + DW'(2);
        end
      end else if (do_pop) begin
        active_q <= tos;
        depth_q  <= depth_q - DW'(1);
      end else begin
        active_q.pc <= cand_pc;
      end
    end
  end

  // Stack contents need no reset; the depth counter alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (DW'(i) == depth_q) begin
          stack_q[i] <= '{pc: recon_pc, mask: active_q.mask, rpc: active_q.rpc};
        end
        if (!single_push && (DW'(i) == depth_q + DW'(1))) begin
          stack_q[i] <= '{pc: tgt_pc, mask: taken, rpc: recon_pc};
        end
      end
    end
  end

  assign bus.current_pc     = active_q.pc;
  assign bus.active_mask    = active_q.mask;
  assign bus.stack_depth    = depth_q;
  assign bus.stack_overflow = overflow_q;
endmodule

// File: tb/tb_simt_pc_stack.sv
// Directed bench for simt_pc_stack: two instances (stack depth 4 and 2) driven with identical stimulus.
module tb_simt_pc_stack;
  logic        clk;
  logic        reset;
  logic        launch;
  logic [3:0]  thread_enable;
  logic [2:0]  core_state;
  logic        pc_mux;
  logic [2:0]  dnzp;
  logic [7:0]  imm;
  logic [7:0]  rpc;
  logic [11:0] nzp;

  int vectors;
  int miscompares;

  simt_pc_stack_if #(.STACK_DEPTH(4)) bus_a ();
  simt_pc_stack_if #(.STACK_DEPTH(2)) bus_b ();

  assign bus_a.launch            = launch;
  assign bus_a.thread_enable     = thread_enable;
  assign bus_a.core_state        = core_state;
  assign bus_a.decoded_pc_mux    = pc_mux;
  assign bus_a.decoded_nzp       = dnzp;
  assign bus_a.decoded_immediate = imm;
  assign bus_a.decoded_reconv_pc = rpc;
  assign bus_a.nzp               = nzp;
  assign bus_b.launch            = launch;
  assign bus_b.thread_enable     = thread_enable;
  assign bus_b.core_state        = core_state;
  assign bus_b.decoded_pc_mux    = pc_mux;
  assign bus_b.decoded_nzp       = dnzp;
  assign bus_b.decoded_immediate = imm;
  assign bus_b.decoded_reconv_pc = rpc;
  assign bus_b.nzp               = nzp;

  simt_pc_stack #(.STACK_DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  simt_pc_stack #(.STACK_DEPTH(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ln, input logic [3:0] te, input logic [2:0] cs,
                               input logic br, input logic [2:0] dn, input logic [7:0] im,
                               input logic [7:0] rp, input logic [11:0] nz);
    launch = ln; thread_enable = te; core_state = cs;
    pc_mux = br; dnzp = dn; imm = im; rpc = rp; nzp = nz;
    @(posedge clk);
    #1;
    launch = 1'b0; core_state = 3'b000; pc_mux = 1'b0;
  endtask

  task automatic launch_block(input logic [3:0] te);
    applyStimulus(1'b1, te, 3'b000, 1'b0, 3'b000, 8'd0, 8'd0, 12'd0);
  endtask

  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 3'b101, 1'b0, 3'b000, 8'd0, 8'd0, 12'd0);
  endtask

  task automatic branch(input logic [2:0] dn, input logic [7:0] im, input logic [7:0] rp,
                        input logic [11:0] nz);
    applyStimulus(1'b0, 4'd0, 3'b101, 1'b1, dn, im, rp, nz);
  endtask

  task automatic check_a(input string tag, input int pc, input int mask, input int depth);
    checkOutput({tag, "_pc"},    32'(bus_a.current_pc),  pc);
    checkOutput({tag, "_mask"},  32'(bus_a.active_mask), mask);
    checkOutput({tag, "_depth"}, 32'(bus_a.stack_depth), depth);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    launch = 0; thread_enable = 0; core_state = 0; pc_mux = 0;
    dnzp = 0; imm = 0; rpc = 0; nzp = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    check_a("reset", 0, 0, 0);
    checkOutput("reset_ovf", 32'(bus_a.stack_overflow), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a running block
    launch_block(4'b1111);
    run_seq(3);
    checkOutput("prereset_pc", 32'(bus_a.current_pc), 3);
    #3 reset = 1'b0;
    #1;
    check_a("midreset", 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    launch_block(4'b1011);
    check_a("launch", 0, 4'b1011, 0);
    checkOutput("launch_ovf", 32'(bus_a.stack_overflow), 0);
    run_seq(8);
    checkOutput("seq8_pc", 32'(bus_a.current_pc), 8);

    // Uniform branches, taken and not taken
    launch_block(4'b1111);
    run_seq(5);
    branch(3'b010, 8'd20, 8'd0, {4{3'b010}});
    check_a("uni_taken", 20, 4'b1111, 0);
    launch_block(4'b1111);
    run_seq(5);
    branch(3'b100, 8'd20, 8'd0, {4{3'b010}});
    check_a("uni_nottaken", 6, 4'b1111, 0);

    // If/else divergence: lanes 0,1 jump to 10, rest fall through; reconverge at 12
    launch_block(4'b1111);
    run_seq(5);
    branch(3'b100, 8'd10, 8'd12, {3'b001, 3'b001, 3'b100, 3'b100});
    check_a("div", 6, 4'b1100, 2);
    run_seq(5);
    checkOutput("div_run_pc", 32'(bus_a.current_pc), 11);
    run_seq(1);
    check_a("div_pop1", 10, 4'b0011, 1);
    checkOutput("div_pop1_b_pc", 32'(bus_b.current_pc), 10);
    run_seq(2);
    check_a("div_pop2", 12, 4'b1111, 0);

    // If-without-else: lanes 2,3 skip straight to reconvergence PC 9
    launch_block(4'b1111);
    run_seq(3);
    branch(3'b010, 8'd9, 8'd9, {3'b010, 3'b010, 3'b001, 3'b001});
    check_a("ifonly", 4, 4'b0011, 1);
    run_seq(5);
    check_a("ifonly_pop", 9, 4'b1111, 0);

    // Nested divergence at depth 1: fits in the 4-deep stack, overflows the 2-deep one
    launch_block(4'b1111);
    run_seq(3);
    branch(3'b010, 8'd9, 8'd9, {3'b010, 3'b010, 3'b001, 3'b001});
    branch(3'b100, 8'd30, 8'd7, {3'b000, 3'b000, 3'b001, 3'b100});
    checkOutput("ovf_b_flag",  32'(bus_b.stack_overflow), 1);
    checkOutput("ovf_b_pc",    32'(bus_b.current_pc), 30);
    checkOutput("ovf_b_mask",  32'(bus_b.active_mask), 4'b0011);
    checkOutput("ovf_b_depth", 32'(bus_b.stack_depth), 1);
    check_a("nest", 5, 4'b0010, 3);
    checkOutput("nest_a_ovf", 32'(bus_a.stack_overflow), 0);
    run_seq(2);
    check_a("nest_pop", 30, 4'b0001, 2);
    checkOutput("ovf_b_sticky", 32'(bus_b.stack_overflow), 1);
    launch_block(4'b1111);
    checkOutput("ovf_b_cleared", 32'(bus_b.stack_overflow), 0);
    checkOutput("nest_a_cleared_depth", 32'(bus_a.stack_depth), 0);

    // PC wrap, non-EXECUTE hold, launch priority, empty mask
    branch(3'b010, 8'd255, 8'd0, {4{3'b010}});
    checkOutput("wrap_pre", 32'(bus_a.current_pc), 255);
    run_seq(1);
    checkOutput("wrap_pc", 32'(bus_a.current_pc), 0);
    run_seq(3);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 4'd0, 3'b100, 1'b1, 3'b010, 8'd50, 8'd0, {4{3'b010}});
    check_a("hold", 3, 4'b1111, 0);
    applyStimulus(1'b1, 4'b0110, 3'b101, 1'b0, 3'b000, 8'd0, 8'd0, 12'd0);
    check_a("launch_prio", 0, 4'b0110, 0);
    launch_block(4'b0000);
    run_seq(2);
    check_a("empty_mask", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simt_pc_stack.md
Name: simt_pc_stack

Overview:
- Per-block program counter with SIMT divergence/reconvergence, replacing per-thread PC calculation with one shared PC, an active-thread mask and a hardware reconvergence stack.
- Resolves BRnzp per thread against per-thread NZP flags. Divergent paths are serialised and rejoined at the reconvergence PC supplied with the branch.
- Sits in the core between decoder/scheduler and fetcher. The scheduler consumes current_pc and active_mask.

Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes (mask width)
- PROGRAM_MEM_ADDR_BITS, 8, PC width
- DATA_MEM_DATA_BITS, 8, immediate width (low PROGRAM_MEM_ADDR_BITS bits are used as branch target)
- STACK_DEPTH, 4, number of reconvergence stack entries (>=2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- launch  in  1  one-cycle pulse: start block at PC 0
- thread_enable  in  THREADS_PER_BLOCK  lanes valid for this block, sampled on launch
- core_state  in  3  scheduler state; PC updates only when 3'b101 (EXECUTE)
- decoded_pc_mux  in  1  current instruction is BRnzp
- decoded_nzp  in  3  branch condition mask
- decoded_immediate  in  DATA_MEM_DATA_BITS  branch target
- decoded_reconv_pc  in  PROGRAM_MEM_ADDR_BITS  reconvergence PC of the branch
- nzp  in  3*THREADS_PER_BLOCK  per-thread NZP flags, lane i at [3i+2:3i]
- current_pc  out  PROGRAM_MEM_ADDR_BITS  shared PC of active threads
- active_mask  out  THREADS_PER_BLOCK  threads executing at current_pc
- stack_depth  out  $clog2(STACK_DEPTH+1)  valid stack entries
- stack_overflow  out  1  sticky error flag

Behaviour:
- State: active entry {pc, mask, rpc}. Stack of STACK_DEPTH entries {pc, mask, rpc}. Overflow flag. All outputs are registered.
- Reset (reset==0, asynchronous): current_pc=0, active_mask=0, rpc=0, stack_depth=0, stack_overflow=0. Stack contents are don't-care. Reset mid-divergence discards all state.
- launch (priority over EXECUTE): pc=0, mask=thread_enable, depth=0, overflow=0.
- Update occurs on the clk edge where core_state==3'b101 and active_mask!=0. No change in other cycles.
- Per lane: taken[i] = mask[i] & |(nzp[3i+2:3i] & decoded_nzp).
- seq = pc+1, wraps modulo 2^PROGRAM_MEM_ADDR_BITS. tgt = decoded_immediate[PROGRAM_MEM_ADDR_BITS-1:0].
- Uniform case: not branch; or taken==0; or taken==mask; or tgt==seq.
  - cand = tgt if branch and taken!=0, else seq.
  - If depth>0 and cand==rpc: pop, active <= TOS, depth-1.
  - Otherwise pc <= cand; mask and rpc unchanged.
- Divergent case: branch and 0 != taken != mask and tgt != seq. Let R = decoded_reconv_pc, nt = mask & ~taken.
  - Push reconvergence entry {R, mask, rpc}.
  - If seq==R: active <= {tgt, taken, R}. One push.
  - Else if tgt==R: active <= {seq, nt, R}. One push.
  - Else: also push {tgt, taken, R} on top, and active <= {seq, nt, R}. Two pushes.
  - Two pushes in one cycle are allowed. Depth updates by +1 or +2.
  - Divergent branches never pop in the same cycle.
- Overflow: if the required pushes exceed free entries:
  - No push occurs.
  - stack_overflow <= 1 (sticky until reset/launch).
  - Branch resolved uniformly: pc <= tgt, mask unchanged.
- Pop in the same cycle as launch: launch wins.
- Nested divergence is supported up to STACK_DEPTH.

Test Plan:
- Reset low mid-run, then launch with thread_enable=4'b1011 -> current_pc=0, active_mask=1011, depth=0, overflow=0. Eight non-branch EXECUTE cycles -> pc=8.
- Uniform branch: mask=1111, all lanes nzp=010, decoded_nzp=010, imm=20, pc=5 -> pc=20, mask=1111, depth=0. Same with decoded_nzp=100 -> pc=6.
- Divergence: pc=5, mask=1111, lanes 0,1 taken, imm=10, R=12 -> pc=6, mask=1100, depth=2.
  - Run to pc 11 -> pop to pc=10, mask=0011.
  - Run to pc 11 -> pop to pc=12, mask=1111, depth=0.
- If-without-else: pc=3, lanes 2,3 taken, imm=R=9 -> pc=4, mask=0011, depth=1. At cand 9 -> pc=9, mask=1111, depth=0.
- Overflow: STACK_DEPTH=2, depth=1, divergent branch needing 2 pushes, imm=30 -> overflow=1, pc=30, mask unchanged, depth=1.
- Wrap: pc=255, non-branch EXECUTE -> pc=0. core_state!=101 for 5 cycles -> no change.
